lane_gate_controller: RTL and testbench

- Sequences the single shared entry/exit lane barrier of the car park.
- Latches entry and exit requests from the lane buttons and arbitrates them round-robin.
- Drives the barrier motor through open, hold and close phases.
- Emits exactly one car_in or car_out pulse per completed passage to park_system, which owns the spot count. Entry is refused while parking_full is high; exit is always served.

---
 rtl/lane_gate_controller_pkg.sv | 21 ++
 rtl/lane_gate_controller_gate_timer.sv | 27 ++
 rtl/lane_gate_controller.sv | 175 +++++++++++++++++
 tb/tb_lane_gate_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lane_gate_controller_pkg.sv
// Shared definitions for the car-park lane barrier controller: FSM states,
// lane direction encoding and the timer width helper.
package lane_gate_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } gate_state_t;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lane_gate_controller_gate_timer.sv
// Loadable down-counter shared by the open, pass-wait and close phases.
// Saturates at zero; done flags the terminal count.
module lane_gate_controller_gate_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/lane_gate_controller.sv
// Lane barrier sequencer: latches entry/exit requests, arbitrates them
// round-robin and runs the barrier through open, hold and close phases.
//
//   state      | meaning
//   ST_IDLE    | barrier down, arbitrating pending requests
//   ST_OPENING | motor_up, barrier travelling up
//   ST_OPEN    | barrier up, waiting for a car to cross the loop
//   ST_CLOSING | motor_down, held off while the loop is occupied
module lane_gate_controller
    import lane_gate_controller_pkg::*;
#(
    parameter int OPEN_CYCLES  = 4,
    parameter int CLOSE_CYCLES = 4,
    parameter int PASS_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_in,
    input  logic req_out,
    input  logic pass_sensor,
    input  logic parking_full,
    output logic motor_up,
    output logic motor_down,
    output logic gate_open,
    output logic dir_in,
    output logic lane_busy,
    output logic car_in,
    output logic car_out,
    output logic entry_denied,
    output logic pass_timeout
);

    localparam int TW = $clog2(max3(OPEN_CYCLES, CLOSE_CYCLES, PASS_TIMEOUT)) + 1;

    gate_state_t   state_q, state_d;
    logic          pend_in_q, pend_out_q;
    logic          clr_in, clr_out;
    logic          grant_in, grant_out;
    logic          last_grant_q, last_grant_d;
    logic          dir_d;
    logic          sensor_q;
    logic          passage;
    logic          tmr_load, tmr_en, tmr_done;
    logic [TW-1:0] tmr_load_val;
    logic [TW-1:0] tmr_value_unused;
    logic          car_in_d, car_out_d, denied_d, timeout_d;

    assign passage = pass_sensor & ~sensor_q;

    lane_gate_controller_gate_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .value    (tmr_value_unused),
        .done     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dir_d        = dir_in;
        clr_in       = 1'b0;
        clr_out      = 1'b0;
        grant_in     = 1'b0;
        grant_out    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        car_in_d     = 1'b0;
        car_out_d    = 1'b0;
        denied_d     = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Entry wins when alone or when it is entry's turn on a tie;
                // a refused entry hands the lane straight to a waiting exit.
                if (pend_in_q && (!pend_out_q || last_grant_q == DIR_OUT)) begin
                    if (parking_full) begin
                        denied_d  = 1'b1;
                        clr_in    = 1'b1;
                        grant_out = pend_out_q;
                    end else begin
                        grant_in = 1'b1;
                    end
                end else if (pend_out_q) begin
                    grant_out = 1'b1;
                end

                if (grant_in || grant_out) begin
                    state_d      = ST_OPENING;
                    dir_d        = grant_in ? DIR_IN : DIR_OUT;
                    last_grant_d = grant_in ? DIR_IN : DIR_OUT;
                    clr_in       = clr_in | grant_in;
                    clr_out      = grant_out;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(OPEN_CYCLES - 1);
                end
            end

            ST_OPENING: begin
                if (tmr_done) begin
                    state_d      = ST_OPEN;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(PASS_TIMEOUT - 1);
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_OPEN: begin
                if (passage || tmr_done) begin
                    state_d      = ST_CLOSING;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(CLOSE_CYCLES - 1);
                    car_in_d     = passage & (dir_in == DIR_IN);
                    car_out_d    = passage & (dir_in == DIR_OUT);
                    timeout_d    = ~passage;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_CLOSING: begin
                if (pass_sensor) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(CLOSE_CYCLES - 1);
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_in_q    <= 1'b0;
            pend_out_q   <= 1'b0;
            last_grant_q <= DIR_OUT;
            sensor_q     <= 1'b0;
            motor_up     <= 1'b0;
            motor_down   <= 1'b0;
            gate_open    <= 1'b0;
            dir_in       <= 1'b0;
            lane_busy    <= 1'b0;
            car_in       <= 1'b0;
            car_out      <= 1'b0;
            entry_denied <= 1'b0;
            pass_timeout <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_in_q    <= (pend_in_q & ~clr_in) | req_in;
            pend_out_q   <= (pend_out_q & ~clr_out) | req_out;
            last_grant_q <= last_grant_d;
            sensor_q     <= pass_sensor;
            motor_up     <= (state_d == ST_OPENING);
            motor_down   <= (state_d == ST_CLOSING);
            gate_open    <= (state_d == ST_OPEN);
            dir_in       <= dir_d;
            lane_busy    <= (state_d != ST_IDLE);
            car_in       <= car_in_d;
            car_out      <= car_out_d;
            entry_denied <= denied_d;
            pass_timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_lane_gate_controller.sv
// Bench for lane_gate_controller: directed lane scenarios plus a random run,
// all compared cycle by cycle against a phase/cycles-remaining reference model.
module tb_lane_gate_controller;

    localparam int OPEN_CYCLES  = 4;
    localparam int CLOSE_CYCLES = 4;
    localparam int PASS_TIMEOUT = 16;

    localparam int P_IDLE  = 0;
    localparam int P_RAISE = 1;
    localparam int P_UP    = 2;
    localparam int P_LOWER = 3;

    logic clk = 1'b0;
    logic rst, req_in, req_out, pass_sensor, parking_full;
    logic motor_up, motor_down, gate_open, dir_in, lane_busy;
    logic car_in, car_out, entry_denied, pass_timeout;

    always #5 clk = ~clk;

    lane_gate_controller #(
        .OPEN_CYCLES  (OPEN_CYCLES),
        .CLOSE_CYCLES (CLOSE_CYCLES),
        .PASS_TIMEOUT (PASS_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .req_out      (req_out),
        .pass_sensor  (pass_sensor),
        .parking_full (parking_full),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .gate_open    (gate_open),
        .dir_in       (dir_in),
        .lane_busy    (lane_busy),
        .car_in       (car_in),
        .car_out      (car_out),
        .entry_denied (entry_denied),
        .pass_timeout (pass_timeout)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: lane phase and the number of cycles left in it.
    int m_phase, m_left;
    bit m_pin, m_pout, m_last_in, m_dir, m_sq;
    bit m_cin, m_cout, m_deny, m_tmo;

    task automatic model_step(input bit r, input bit ri, input bit ro, input bit s, input bit f);
        bit rise, want_in, want_out, clr_in, clr_out;
        m_cin = 0; m_cout = 0; m_deny = 0; m_tmo = 0;
        if (r) begin
            m_phase = P_IDLE; m_left = 0; m_pin = 0; m_pout = 0;
            m_last_in = 0; m_dir = 0; m_sq = 0;
            return;
        end
        clr_in = 0; clr_out = 0;
        rise = s && !m_sq;
        case (m_phase)
            P_IDLE: begin
                want_in  = m_pin && (!m_pout || !m_last_in);
                want_out = m_pout && !want_in;
                if (want_in && f) begin
                    m_deny = 1; clr_in = 1; want_in = 0; want_out = m_pout;
                end
                if (want_in || want_out) begin
                    m_dir = want_in; m_last_in = want_in;
                    clr_in = clr_in || want_in; clr_out = want_out;
                    m_phase = P_RAISE; m_left = OPEN_CYCLES;
                end
            end
            P_RAISE: begin
                m_left--;
                if (m_left == 0) begin m_phase = P_UP; m_left = PASS_TIMEOUT; end
            end
            P_UP: begin
                if (rise) begin
                    m_phase = P_LOWER; m_left = CLOSE_CYCLES;
                    m_cin = m_dir; m_cout = !m_dir;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_LOWER; m_left = CLOSE_CYCLES; m_tmo = 1; end
                end
            end
            default: begin
                if (s) m_left = CLOSE_CYCLES;
                else begin
                    m_left--;
                    if (m_left == 0) m_phase = P_IDLE;
                end
            end
        endcase
        m_sq   = s;
        m_pin  = (m_pin && !clr_in) || ri;
        m_pout = (m_pout && !clr_out) || ro;
    endtask

    int cyc = 0;
    int n_cin = 0, n_cout = 0, n_deny = 0, n_tmo = 0, n_busy = 0, n_up = 0;
    int first_in = -1, first_out = -1;

    // One clock: check the outputs of the previous edge, drive the next inputs.
    task automatic cycle(input bit r, input bit ri, input bit ro, input bit s, input bit f);
        bit m_busy;
        m_busy = (m_phase != P_IDLE);
        check_eq("outputs",
                 {motor_up, motor_down, gate_open, dir_in & lane_busy, lane_busy,
                  car_in, car_out, entry_denied, pass_timeout},
                 {m_phase == P_RAISE, m_phase == P_LOWER, m_phase == P_UP, m_dir & m_busy,
                  m_busy, m_cin, m_cout, m_deny, m_tmo});
        check_eq("motor_excl", {31'd0, motor_up & motor_down}, 32'd0);
        check_eq("pulse_excl", ($countones({car_in, car_out, entry_denied, pass_timeout}) <= 1), 1);
        n_cin  += car_in;
        n_cout += car_out;
        n_deny += entry_denied;
        n_tmo  += pass_timeout;
        n_busy += lane_busy;
        n_up   += motor_up;
        if (car_in  && first_in  < 0) first_in  = cyc;
        if (car_out && first_out < 0) first_out = cyc;
        cyc++;
        rst = r; req_in = ri; req_out = ro; pass_sensor = s; parking_full = f;
        model_step(r, ri, ro, s, f);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit ri, input bit ro, input bit s, input bit f);
        for (int i = 0; i < n; i++) cycle(1'b0, ri, ro, s, f);
    endtask

    initial begin
        int b_cin, b_cout, b_deny, b_tmo, b_busy, b_up;
        bit s, f, r, ri, ro;

        rst = 1; req_in = 0; req_out = 0; pass_sensor = 0; parking_full = 0;
        model_step(1, 0, 0, 0, 0);
        @(negedge clk);
        cycle(1, 0, 0, 0, 0);

        // Single entry with a passing car.
        b_cin = n_cin; b_cout = n_cout; b_up = n_up;
        cycle(0, 1, 0, 0, 0);
        run(8, 0, 0, 0, 0);
        run(2, 0, 0, 1, 0);
        run(10, 0, 0, 0, 0);
        check_eq("entry_car_in", n_cin - b_cin, 1);
        check_eq("entry_car_out", n_cout - b_cout, 0);
        check_eq("entry_motor_up_cycles", n_up - b_up, OPEN_CYCLES);

        // Lot full: entry refused, barrier untouched.
        b_deny = n_deny; b_busy = n_busy; b_up = n_up;
        cycle(0, 1, 0, 0, 1);
        run(5, 0, 0, 0, 1);
        check_eq("full_denied", n_deny - b_deny, 1);
        check_eq("full_busy", n_busy - b_busy, 0);
        check_eq("full_motor_up", n_up - b_up, 0);

        // Simultaneous requests after reset: entry first, then exit.
        run(2, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        b_cin = n_cin; b_cout = n_cout; first_in = -1; first_out = -1;
        cycle(0, 1, 1, 0, 0);
        run(8, 0, 0, 0, 0);
        run(2, 0, 0, 1, 0);
        run(10, 0, 0, 0, 0);
        run(2, 0, 0, 1, 0);
        run(10, 0, 0, 0, 0);
        check_eq("tie_car_in", n_cin - b_cin, 1);
        check_eq("tie_car_out", n_cout - b_cout, 1);
        check_eq("tie_order", (first_in >= 0) && (first_in < first_out), 1);

        // Exit with no passage: timeout, no count pulse.
        b_cout = n_cout; b_tmo = n_tmo;
        cycle(0, 0, 1, 0, 0);
        run(30, 0, 0, 0, 0);
        check_eq("timeout_pulse", n_tmo - b_tmo, 1);
        check_eq("timeout_car_out", n_cout - b_cout, 0);

        // Car lingering under the barrier during closing.
        b_cin = n_cin; b_cout = n_cout;
        cycle(0, 0, 1, 0, 0);
        run(8, 0, 0, 0, 0);
        run(7, 0, 0, 1, 0);
        run(12, 0, 0, 0, 0);
        check_eq("linger_pulses", (n_cin - b_cin) + (n_cout - b_cout), 1);

        // Reset while open with an exit pending: the request is dropped.
        cycle(0, 1, 0, 0, 0);
        run(7, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        b_cin = n_cin; b_cout = n_cout; b_busy = n_busy;
        run(30, 0, 0, 0, 0);
        check_eq("rst_busy", n_busy - b_busy, 0);
        check_eq("rst_pulses", (n_cin - b_cin) + (n_cout - b_cout), 0);

        // Random traffic.
        s = 0; f = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0)  s = ~s;
            if ($urandom_range(29) == 0) f = ~f;
            r  = ($urandom_range(599) == 0);
            ri = ($urandom_range(11) == 0);
            ro = ($urandom_range(11) == 0);
            cycle(r, ri, ro, s, f);
        end
        check_eq("random_saw_cars", (n_cin > 3) && (n_cout > 3), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
